// File: rtl/eeprom_page_writer.sv
// 28C256 in-system page programmer: Z80 I/O window loads a 64-byte page buffer, commit runs a timed WE_B burst.
// Optional `DATA_POLL_EN replaces the fixed write-cycle wait with DATA# polling plus timeout.
module eeprom_page_writer #(
    parameter logic [7:0]  PORT_HI          = 8'hFB,
    parameter int unsigned WE_LOW_CLKS      = 2,
    parameter int unsigned WRITE_CYCLE_CLKS = 40000,
    parameter int unsigned POLL_INTERVAL    = 64
) (
    input  logic        CLK,
    input  logic        RESET_B,
    input  logic        IOREQ_B,
    input  logic        WR_B,
    input  logic        RD_B,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic [14:0] ee_a,
    output logic [7:0]  ee_d_out,
    output logic        ee_d_oe,
    input  logic [7:0]  ee_d_in,
    output logic [3:0]  ee_cs_b,
    output logic [3:0]  ee_we_b,
    output logic        ee_oe_b,
    output logic        busy
);
    localparam int unsigned WE_W = (WE_LOW_CLKS > 1) ? $clog2(WE_LOW_CLKS) : 1;
    localparam int unsigned WC_W = $clog2(WRITE_CYCLE_CLKS + 1);
    localparam logic [WE_W-1:0] WE_LAST = WE_W'(WE_LOW_CLKS - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WRITE_CYCLE_CLKS);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_HOLD,
`ifdef DATA_POLL_EN
        S_POLL,
`else
        S_WAIT_WC,
`endif
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [1:0]      iorq_sync, wr_sync, rd_sync;
    logic            wr_act, wr_act_d, wr_evt, port_hit, commit;
    logic [13:0]     page_addr;
    logic [6:0]      count, idx;
    logic [2:0]      slot;
    logic            err, full;
    logic [WE_W-1:0] we_cnt;
    logic [WC_W-1:0] wc_cnt;
    logic [5:0]      cur_col, wr_col;
    logic [7:0]      cur_byte;
    logic [7:0]      page_buf [64];
    logic            unused;

    assign port_hit = (A[15:8] == PORT_HI);
    assign wr_act   = ~iorq_sync[1] & ~wr_sync[1] & port_hit;
    assign wr_evt   = wr_act & ~wr_act_d;
    assign busy     = (state != S_IDLE);
    assign commit   = wr_evt & ~busy & (A[1:0] == 2'd3) & D_in[7] & (count != 7'd0);
    assign cur_col  = page_addr[5:0] + idx[5:0];
    assign wr_col   = page_addr[5:0] + count[5:0];
    assign cur_byte = page_buf[cur_col];
    assign D_oe     = ~iorq_sync[1] & ~rd_sync[1] & port_hit & A[1];
    assign D_out    = A[0] ? {busy, err, full, 2'b00, slot} : {1'b0, count};
    assign unused   = ^{A[7:2], ee_d_in};

`ifdef DATA_POLL_EN
    localparam int unsigned PI_W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 2;
    localparam logic [PI_W-1:0] PI_LAST   = PI_W'(POLL_INTERVAL - 1);
    localparam logic [PI_W-1:0] PI_STROBE = PI_W'(POLL_INTERVAL - 2);
    logic [PI_W-1:0] poll_cnt;
    logic            poll_strobe, poll_match;
    // Read strobe occupies the last two cycles of each interval; data bit 7 sampled on the second.
    assign poll_strobe = (state == S_POLL) && (poll_cnt >= PI_STROBE);
    assign poll_match  = (state == S_POLL) && (poll_cnt == PI_LAST) && (ee_d_in[7] == cur_byte[7]);
`endif

    always_ff @(posedge CLK) begin
        if (wr_evt && !busy && (A[1:0] == 2'd2) && (count != 7'd64))
            page_buf[wr_col] <= D_in;
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) state <= S_IDLE;
        else          state <= next_state;
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            iorq_sync <= '1;
            wr_sync   <= '1;
            rd_sync   <= '1;
            wr_act_d  <= 1'b0;
            page_addr <= '0;
            count     <= '0;
            idx       <= '0;
            slot      <= '0;
            err       <= 1'b0;
            full      <= 1'b0;
            we_cnt    <= '0;
            wc_cnt    <= '0;
`ifdef DATA_POLL_EN
            poll_cnt  <= '0;
`endif
        end else begin
            iorq_sync <= {iorq_sync[0], IOREQ_B};
            wr_sync   <= {wr_sync[0], WR_B};
            rd_sync   <= {rd_sync[0], RD_B};
            wr_act_d  <= wr_act;
            if (wr_evt) begin
                if (busy) begin
                    err <= 1'b1;
                end else begin
                    case (A[1:0])
                        2'd0: page_addr[7:0]  <= D_in;
                        2'd1: page_addr[13:8] <= D_in[5:0];
                        2'd2: if (count == 7'd64) full <= 1'b1;
                              else                count <= count + 7'd1;
                        default: begin
                            slot <= D_in[2:0];
                            if (commit) begin
                                err  <= 1'b0;
                                full <= 1'b0;
                            end
                        end
                    endcase
                end
            end
            we_cnt <= (state == S_PULSE) ? we_cnt + 1'b1 : '0;
            if (state == S_IDLE) idx <= '0;
            else if (state == S_HOLD && (idx + 7'd1 < count)) idx <= idx + 7'd1;
            if (state == S_DONE) count <= '0;
`ifdef DATA_POLL_EN
            wc_cnt   <= (state == S_POLL) ? wc_cnt + 1'b1 : '0;
            poll_cnt <= (state == S_POLL && poll_cnt != PI_LAST) ? poll_cnt + 1'b1 : '0;
            if (state == S_POLL && wc_cnt == WC_LAST && !poll_match) err <= 1'b1;
`else
            wc_cnt <= (state == S_WAIT_WC) ? wc_cnt + 1'b1 : '0;
`endif
        end
    end

    always_comb begin
        next_state = state;
        ee_a       = {slot[0], page_addr[13:6], cur_col};
        ee_d_out   = cur_byte;
        ee_d_oe    = 1'b0;
        ee_cs_b    = '1;
        ee_we_b    = '1;
        ee_oe_b    = 1'b1;
        case (state)
            S_IDLE: if (commit) next_state = S_SETUP;
            S_SETUP: begin
                ee_d_oe              = 1'b1;
                ee_cs_b[slot[2:1]]   = 1'b0;
                next_state           = S_PULSE;
            end
            S_PULSE: begin
                ee_d_oe              = 1'b1;
                ee_cs_b[slot[2:1]]   = 1'b0;
                ee_we_b[slot[2:1]]   = 1'b0;
                if (we_cnt == WE_LAST) next_state = S_HOLD;
            end
            S_HOLD: begin
                ee_d_oe              = 1'b1;
                ee_cs_b[slot[2:1]]   = 1'b0;
                if (idx + 7'd1 < count) next_state = S_SETUP;
`ifdef DATA_POLL_EN
                else                    next_state = S_POLL;
`else
                else                    next_state = S_WAIT_WC;
`endif
            end
`ifdef DATA_POLL_EN
            S_POLL: begin
                if (poll_strobe) begin
                    ee_cs_b[slot[2:1]] = 1'b0;
                    ee_oe_b            = 1'b0;
                end
                if (poll_match || wc_cnt == WC_LAST) next_state = S_DONE;
            end
`else
            S_WAIT_WC: if (wc_cnt == WC_LAST) next_state = S_DONE;
`endif
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_eeprom_page_writer.sv
// Directed bench for eeprom_page_writer: register table plus burst, wrap, full, err and reset sequences.
module tb_eeprom_page_writer;
    localparam int TB_WE = 2;
    localparam int TB_WC = 200;

    logic        CLK = 1'b0;
    logic        RESET_B = 1'b0;
    logic        IOREQ_B = 1'b1, WR_B = 1'b1, RD_B = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_in = 8'h00;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [14:0] ee_a;
    logic [7:0]  ee_d_out;
    logic        ee_d_oe;
    logic [7:0]  ee_d_in = 8'h00;
    logic [3:0]  ee_cs_b, ee_we_b;
    logic        ee_oe_b;
    logic        busy;

    eeprom_page_writer #(
        .PORT_HI(8'hFB), .WE_LOW_CLKS(TB_WE), .WRITE_CYCLE_CLKS(TB_WC), .POLL_INTERVAL(64)
    ) dut (
        .CLK(CLK), .RESET_B(RESET_B), .IOREQ_B(IOREQ_B), .WR_B(WR_B), .RD_B(RD_B),
        .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .ee_a(ee_a), .ee_d_out(ee_d_out), .ee_d_oe(ee_d_oe), .ee_d_in(ee_d_in),
        .ee_cs_b(ee_cs_b), .ee_we_b(ee_we_b), .ee_oe_b(ee_oe_b), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;

    // Pulse recorder: one entry per WE_B falling edge seen at negedge.
    int          n_pulses = 0;
    int          busy_total = 0;
    logic [3:0]  prev_we = 4'hF;
    logic [14:0] p_addr [256];
    logic [7:0]  p_data [256];
    logic [3:0]  p_we   [256];
    logic [3:0]  p_cs   [256];
    logic        p_doe  [256];
    int          p_len  [256];

    always @(negedge CLK) begin
        if (busy) busy_total++;
        if (ee_we_b != 4'hF) begin
            if (prev_we == 4'hF && n_pulses < 256) begin
                p_addr[n_pulses] = ee_a;
                p_data[n_pulses] = ee_d_out;
                p_we[n_pulses]   = ee_we_b;
                p_cs[n_pulses]   = ee_cs_b;
                p_doe[n_pulses]  = ee_d_oe;
                p_len[n_pulses]  = 0;
                n_pulses++;
            end
            if (n_pulses > 0) p_len[n_pulses-1]++;
        end
        prev_we = ee_we_b;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic io_write(input logic [1:0] rg, input logic [7:0] d);
        @(negedge CLK);
        A = {8'hFB, 6'b0, rg};
        D_in = d;
        IOREQ_B = 1'b0;
        WR_B = 1'b0;
        repeat (5) @(negedge CLK);
        IOREQ_B = 1'b1;
        WR_B = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic io_read(input logic [1:0] rg, output logic [7:0] d, output logic oe);
        @(negedge CLK);
        A = {8'hFB, 6'b0, rg};
        IOREQ_B = 1'b0;
        RD_B = 1'b0;
        repeat (3) @(negedge CLK);
        d = D_out;
        oe = D_oe;
        IOREQ_B = 1'b1;
        RD_B = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] rg, input logic [7:0] exp);
        logic [7:0] d;
        logic       oe;
        io_read(rg, d, oe);
        chk({nm, "_oe"}, {31'd0, oe}, 32'd1);
        chk(nm, {24'd0, d}, {24'd0, exp});
    endtask

    task automatic wait_idle(input string nm, input int max);
        int k = 0;
        while (busy && k < max) begin
            @(negedge CLK);
            k++;
        end
        chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        bit         rd;
        logic [1:0] rg;
        logic [7:0] data;
        logic [7:0] exp;
        bit         exp_oe;
    } vec_t;

    vec_t tv [12];

    initial begin
        int base, bt0;
        logic [7:0] d;
        logic       oe;

        tv[0]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b1};
        tv[1]  = '{1'b1, 2'd2, 8'h00, 8'h00, 1'b1};
        tv[2]  = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b0};
        tv[3]  = '{1'b0, 2'd1, 8'h12, 8'h00, 1'b0};
        tv[4]  = '{1'b0, 2'd0, 8'h40, 8'h00, 1'b0};
        tv[5]  = '{1'b0, 2'd2, 8'hA5, 8'h00, 1'b0};
        tv[6]  = '{1'b1, 2'd2, 8'h00, 8'h01, 1'b1};
        tv[7]  = '{1'b0, 2'd2, 8'h5A, 8'h00, 1'b0};
        tv[8]  = '{1'b0, 2'd2, 8'hC3, 8'h00, 1'b0};
        tv[9]  = '{1'b1, 2'd2, 8'h00, 8'h03, 1'b1};
        tv[10] = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b1};
        tv[11] = '{1'b1, 2'd1, 8'h00, 8'h00, 1'b0};

        repeat (3) @(negedge CLK);
        RESET_B = 1'b1;
        @(negedge CLK);
        chk("rst_we",    {28'd0, ee_we_b}, 32'hF);
        chk("rst_cs",    {28'd0, ee_cs_b}, 32'hF);
        chk("rst_oe",    {31'd0, ee_oe_b}, 32'd1);
        chk("rst_d_oe",  {31'd0, ee_d_oe}, 32'd0);
        chk("rst_busy",  {31'd0, busy},    32'd0);
        chk("rst_D_oe",  {31'd0, D_oe},    32'd0);

        for (int i = 0; i < 12; i++) begin
            if (tv[i].rd) begin
                io_read(tv[i].rg, d, oe);
                chk($sformatf("tv%0d_oe", i), {31'd0, oe}, {31'd0, tv[i].exp_oe});
                if (tv[i].exp_oe) chk($sformatf("tv%0d_dout", i), {24'd0, d}, {24'd0, tv[i].exp});
            end else begin
                io_write(tv[i].rg, tv[i].data);
            end
        end

        // Three-byte burst, slot 3 -> pair 1, bit 14 set
        base = n_pulses;
        bt0 = busy_total;
        io_write(2'd3, 8'h83);
        wait_idle("b1", 1000);
        chk("b1_npulse", n_pulses - base, 3);
        chk("b1_busy", busy_total - bt0, 3 * (TB_WE + 2) + TB_WC + 2);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ed [3];
            ed[0] = 8'hA5; ed[1] = 8'h5A; ed[2] = 8'hC3;
            chk($sformatf("b1_addr%0d", k), {17'd0, p_addr[base+k]}, 32'h5240 + k);
            chk($sformatf("b1_data%0d", k), {24'd0, p_data[base+k]}, {24'd0, ed[k]});
            chk($sformatf("b1_we%0d", k),   {28'd0, p_we[base+k]},   32'hD);
            chk($sformatf("b1_cs%0d", k),   {28'd0, p_cs[base+k]},   32'hD);
            chk($sformatf("b1_doe%0d", k),  {31'd0, p_doe[base+k]},  32'd1);
            chk($sformatf("b1_len%0d", k),  p_len[base+k],           TB_WE);
        end
        rd_chk("b1_count", 2'd2, 8'h00);
        rd_chk("b1_stat",  2'd3, 8'h03);
        chk("b1_ee_oe", {31'd0, ee_oe_b}, 32'd1);

        // Column wrap: start 3E, page bits stay 0x1200
        io_write(2'd0, 8'h3E);
        io_write(2'd2, 8'h11);
        io_write(2'd2, 8'h22);
        io_write(2'd2, 8'h33);
        io_write(2'd2, 8'h44);
        base = n_pulses;
        io_write(2'd3, 8'h80);
        wait_idle("wrap", 1000);
        chk("wrap_npulse", n_pulses - base, 4);
        for (int k = 0; k < 4; k++) begin
            logic [14:0] ea [4];
            ea[0] = 15'h123E; ea[1] = 15'h123F; ea[2] = 15'h1200; ea[3] = 15'h1201;
            chk($sformatf("wrap_addr%0d", k), {17'd0, p_addr[base+k]}, {17'd0, ea[k]});
            chk($sformatf("wrap_data%0d", k), {24'd0, p_data[base+k]}, 32'h11 * (k + 1));
            chk($sformatf("wrap_we%0d", k),   {28'd0, p_we[base+k]},   32'hE);
        end

        // Write during WAIT_WC is dropped and flags err; next accepted commit clears it
        io_write(2'd0, 8'h00);
        io_write(2'd2, 8'h77);
        base = n_pulses;
        io_write(2'd3, 8'h80);
        io_write(2'd2, 8'h99);
        rd_chk("err_busy_stat", 2'd3, 8'hC0);
        wait_idle("err", 1000);
        chk("err_npulse", n_pulses - base, 1);
        chk("err_data", {24'd0, p_data[base]}, 32'h77);
        rd_chk("err_stat",  2'd3, 8'h40);
        rd_chk("err_count", 2'd2, 8'h00);
        io_write(2'd2, 8'h55);
        base = n_pulses;
        io_write(2'd3, 8'h80);
        rd_chk("err_clr_stat", 2'd3, 8'h80);
        wait_idle("err2", 1000);
        chk("err2_addr", {17'd0, p_addr[base]}, 32'h1200);
        chk("err2_data", {24'd0, p_data[base]}, 32'h55);

        // 65 writes: 65th dropped, count saturates at 64, full set
        io_write(2'd0, 8'h10);
        for (int k = 0; k < 65; k++) io_write(2'd2, k[7:0]);
        rd_chk("full_count", 2'd2, 8'h40);
        rd_chk("full_stat",  2'd3, 8'h20);
        base = n_pulses;
        io_write(2'd3, 8'h80);
        rd_chk("full_clr_stat", 2'd3, 8'h80);
        wait_idle("full", 3000);
        chk("full_npulse", n_pulses - base, 64);
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("full_addr%0d", k), {17'd0, p_addr[base+k]}, 32'h1200 + ((32'h10 + k) % 64));
            chk($sformatf("full_data%0d", k), {24'd0, p_data[base+k]}, k);
        end

        // Asynchronous reset in the middle of a WE pulse
        io_write(2'd2, 8'hAA);
        @(negedge CLK);
        A = 16'hFB03;
        D_in = 8'h80;
        IOREQ_B = 1'b0;
        WR_B = 1'b0;
        begin
            int k = 0;
            while (ee_we_b == 4'hF && k < 40) begin
                @(negedge CLK);
                k++;
            end
        end
        chk("rstp_in_pulse", {28'd0, ee_we_b}, 32'hE);
        RESET_B = 1'b0;
        #1;
        chk("rstp_we",   {28'd0, ee_we_b}, 32'hF);
        chk("rstp_cs",   {28'd0, ee_cs_b}, 32'hF);
        chk("rstp_busy", {31'd0, busy},    32'd0);
        chk("rstp_doe",  {31'd0, ee_d_oe}, 32'd0);
        IOREQ_B = 1'b1;
        WR_B = 1'b1;
        repeat (2) @(negedge CLK);
        RESET_B = 1'b1;
        repeat (2) @(negedge CLK);
        rd_chk("rstp_count", 2'd2, 8'h00);
        rd_chk("rstp_stat",  2'd3, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
